// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch front end
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_STEP = 4;
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } queue_entry_t;

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - in-order instruction FIFO with flush; head reads as zero when empty
module inst_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  queue_entry_t wr_entry,
    output queue_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    queue_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    // A pop on an empty queue has nothing to remove; a push into a full queue
    // is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC/ROM fetcher feeding an in-order issue queue; FETCH_STATS_EN adds counters
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          ROM_BYTES   = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_nrd,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        issue_ready,
    output logic        issue_valid,
    output logic [31:0] issue_inst,
    output logic [31:0] issue_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall_cycles,
`endif
    output logic        fetch_halted
);

    localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - PC_STEP);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         q_full;
    logic         q_empty;
    queue_entry_t q_head;
    queue_entry_t q_wr;
    logic         pop;
    logic         in_range;
    logic         fetch_en;
    logic         halt_word;

    assign pop       = issue_valid && issue_ready;
    assign in_range  = (pc <= LAST_PC);
    assign halt_word = (rom_data[31:26] == HALT_OPCODE);
    // Gated by rst_n so the ROM strobe stays idle while reset is held.
    assign fetch_en  = rst_n && (state == FETCH) && in_range && !redirect_valid
                       && (!q_full || pop);

    assign rom_nrd      = !fetch_en;
    assign rom_addr     = pc;
    assign issue_valid  = !q_empty;
    assign issue_inst   = q_head.inst;
    assign issue_pc     = q_head.pc;
    assign fetch_halted = (state == HALTED);
    assign q_wr         = '{inst: rom_data, pc: pc};

    inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fetch_en),
        .pop      (pop && !redirect_valid),
        .flush    (redirect_valid),
        .wr_entry (q_wr),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else if (redirect_valid) begin
            state <= FETCH;
            pc    <= {redirect_pc[31:2], 2'b00};
        end else if (state == FETCH) begin
            if (fetch_en) begin
                pc <= pc + 32'(PC_STEP);
                if (halt_word) state <= HALTED;
            end else if (!in_range) begin
                state <= HALTED;
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Counters survive redirects and stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (fetch_en && stat_fetched != 32'hFFFF_FFFF)
                stat_fetched <= stat_fetched + 1'b1;
            if (state == FETCH && q_full && !pop && stat_stall_cycles != 32'hFFFF_FFFF)
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench with a queue-based fetch model
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_nrd;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        issue_ready = 1'b0;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [31:0] issue_pc;
    logic        fetch_halted;

    int total = 0;
    int bad = 0;

    logic [31:0] rom_mem [25];

    logic [63:0] mq [$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          exp_nrd;
    logic        act_nrd;
    logic [31:0] act_addr;
    logic [31:0] exp_addr;

    inst_fetch_unit #(.QUEUE_DEPTH(4), .RESET_PC(32'h0), .ROM_BYTES(100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_nrd        (rom_nrd),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .issue_ready    (issue_ready),
        .issue_valid    (issue_valid),
        .issue_inst     (issue_inst),
        .issue_pc       (issue_pc),
        .fetch_halted   (fetch_halted)
    );

    always #5 clk = ~clk;

    // Outside the ROM the bus returns a halt-looking word so a stray fetch is visible.
    assign rom_data = (rom_addr < 32'd100) ? rom_mem[int'(rom_addr >> 2)] : 32'hFFFF_FFFF;

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic fill_rom_plain();
        for (int i = 0; i < 25; i++) rom_mem[i] = plain_word();
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0;
        m_halted = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        issue_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive at negedge, record strobe/address, advance the model at posedge.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit pop;
        bit fe;
        logic [31:0] w;
        redirect_valid = redir;
        redirect_pc = rpc;
        issue_ready = rdy;
        #1;
        pop = (mq.size() > 0) && rdy;
        fe = !m_halted && (m_pc <= 32'd96) && !redir && ((mq.size() < 4) || pop);
        exp_nrd = !fe;
        exp_addr = m_pc;
        act_nrd = rom_nrd;
        act_addr = rom_addr;
        @(posedge clk);
        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            m_halted = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (fe) begin
                w = rom_mem[int'(m_pc >> 2)];
                mq.push_back({w, m_pc});
                if (w[31:26] == 6'h3F) m_halted = 1'b1;
                m_pc = m_pc + 32'd4;
            end else if (!m_halted && m_pc > 32'd96) begin
                m_halted = 1'b1;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (issue_valid !== 1'b0 || issue_inst !== 32'h0 || issue_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_issue: valid=%b inst=%h pc=%h expected 0/0/0", issue_valid, issue_inst, issue_pc);
        end
        total++;
        if (rom_nrd !== 1'b1 || rom_addr !== 32'h0 || fetch_halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_fetch: nrd=%b addr=%h halted=%b expected 1/0/0", rom_nrd, rom_addr, fetch_halted);
        end
    endtask

    task automatic test_basic();
        logic [31:0] words [3];
        words[0] = 32'h2001_0005;
        words[1] = 32'h2002_0003;
        words[2] = 32'h0022_1820;
        fill_rom_plain();
        for (int i = 0; i < 3; i++) rom_mem[i] = words[i];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            total++;
            if (issue_valid !== 1'b1 || issue_pc !== 32'(i * 4) || issue_inst !== words[i]) begin
                bad++;
                $display("FAIL basic_seq%0d: valid=%b pc=%h inst=%h expected 1/%h/%h",
                         i, issue_valid, issue_pc, issue_inst, 32'(i * 4), words[i]);
            end
        end
    endtask

    task automatic test_stall();
        fill_rom_plain();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            if (i >= 4) begin
                total++;
                if (act_nrd !== 1'b1 || act_addr !== 32'd16) begin
                    bad++;
                    $display("FAIL stall_hold%0d: nrd=%b addr=%h expected 1/00000010", i, act_nrd, act_addr);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (issue_valid !== 1'b1 || issue_pc !== 32'(i * 4) || issue_inst !== rom_mem[i]) begin
                bad++;
                $display("FAIL stall_drain%0d: valid=%b pc=%h inst=%h expected 1/%h/%h",
                         i, issue_valid, issue_pc, issue_inst, 32'(i * 4), rom_mem[i]);
            end
            cycle(1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_redirect();
        fill_rom_plain();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_002E, 1'b1);
        total++;
        if (issue_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_flush: valid=%b expected 0", issue_valid);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            total++;
            if (issue_valid !== 1'b1 || issue_pc !== 32'h2C + 32'(i * 4)) begin
                bad++;
                $display("FAIL redirect_seq%0d: valid=%b pc=%h expected 1/%h",
                         i, issue_valid, issue_pc, 32'h2C + 32'(i * 4));
            end
        end
    endtask

    task automatic test_halt();
        fill_rom_plain();
        rom_mem[2] = 32'hFC00_0000;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            total++;
            if (issue_valid !== 1'b1 || issue_pc !== 32'(i * 4) || issue_inst !== rom_mem[i]) begin
                bad++;
                $display("FAIL halt_issue%0d: valid=%b pc=%h inst=%h expected 1/%h/%h",
                         i, issue_valid, issue_pc, issue_inst, 32'(i * 4), rom_mem[i]);
            end
        end
        total++;
        if (fetch_halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_flag: halted=%b expected 1", fetch_halted);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            total++;
            if (act_nrd !== 1'b1 || issue_valid !== 1'b0 || fetch_halted !== 1'b1) begin
                bad++;
                $display("FAIL halt_idle%0d: nrd=%b valid=%b halted=%b expected 1/0/1",
                         i, act_nrd, issue_valid, fetch_halted);
            end
        end
        cycle(1'b1, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (fetch_halted !== 1'b0 || issue_valid !== 1'b1 || issue_pc !== 32'h0) begin
            bad++;
            $display("FAIL halt_resume: halted=%b valid=%b pc=%h expected 0/1/00000000",
                     fetch_halted, issue_valid, issue_pc);
        end
    endtask

    task automatic test_range();
        logic [31:0] max_pc;
        bit fetched_100;
        max_pc = '0;
        fetched_100 = 1'b0;
        fill_rom_plain();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (act_nrd === 1'b0 && act_addr === 32'd100) fetched_100 = 1'b1;
            if (issue_valid === 1'b1 && issue_pc > max_pc) max_pc = issue_pc;
        end
        total++;
        if (max_pc !== 32'd96 || fetch_halted !== 1'b1) begin
            bad++;
            $display("FAIL range_end: last_pc=%h halted=%b expected 00000060/1", max_pc, fetch_halted);
        end
        total++;
        if (fetched_100) begin
            bad++;
            $display("FAIL range_overrun: fetch at 100 observed=1 expected 0");
        end
    endtask

    task automatic test_async_reset();
        fill_rom_plain();
        do_reset();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (issue_valid !== 1'b0 || clk !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: valid=%b clk=%b expected 0/0", issue_valid, clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (act_addr !== 32'h0 || issue_valid !== 1'b1 || issue_pc !== 32'h0 || issue_inst !== rom_mem[0]) begin
            bad++;
            $display("FAIL async_restart: addr=%h valid=%b pc=%h inst=%h expected 0/1/0/%h",
                     act_addr, issue_valid, issue_pc, issue_inst, rom_mem[0]);
        end
    endtask

    task automatic test_random();
        bit redir;
        logic [31:0] rpc;
        logic [63:0] hd;
        for (int i = 0; i < 25; i++) begin
            rom_mem[i] = plain_word();
            if ($urandom_range(0, 9) == 0) rom_mem[i][31:26] = 6'h3F;
        end
        do_reset();
        for (int n = 0; n < 600; n++) begin
            redir = ($urandom_range(0, 19) == 0);
            rpc = 32'($urandom_range(0, 110));
            cycle(redir, rpc, $urandom_range(0, 9) < 7);
            hd = (mq.size() > 0) ? mq[0] : 64'h0;
            total++;
            if (issue_valid !== (mq.size() > 0) || issue_pc !== hd[31:0] || issue_inst !== hd[63:32]) begin
                bad++;
                $display("FAIL rand_head%0d: valid=%b pc=%h inst=%h expected %b/%h/%h",
                         n, issue_valid, issue_pc, issue_inst, mq.size() > 0, hd[31:0], hd[63:32]);
            end
            total++;
            if (act_nrd !== exp_nrd || act_addr !== exp_addr || fetch_halted !== m_halted) begin
                bad++;
                $display("FAIL rand_fetch%0d: nrd=%b addr=%h halted=%b expected %b/%h/%b",
                         n, act_nrd, act_addr, fetch_halted, exp_nrd, exp_addr, m_halted);
            end
        end
    endtask

    initial begin
        fill_rom_plain();
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_halt();
        test_range();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
